// File: rtl/smith_waterman.sv
// Smith-Waterman local-alignment engine with affine gaps on 2-bit DNA symbols.
// Loads reference T once, then scores streamed S chunks cell by cell against all of T.
module smith_waterman #(
  parameter int unsigned PE_Array_size_log = 6,
  parameter int unsigned V_E_F_Bit         = 16,
  parameter int unsigned T_MAX_WORDS       = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_set_t,
  input  logic                              i_start_cal,
  output logic                              o_busy,
  output logic [V_E_F_Bit-1:0]              o_result,
  output logic                              o_valid,
  output logic                              o_request_s,
  input  logic [17:0]                       i_t,
  input  logic [(2 << PE_Array_size_log)-1:0] i_s,
  input  logic [PE_Array_size_log:0]        i_s_valid,
  input  logic [3:0]                        i_match,
  input  logic [3:0]                        i_mismatch,
  input  logic [3:0]                        i_minusAlpha,
  input  logic [3:0]                        i_minusBeta
);

  localparam int unsigned PE_NUM  = 1 << PE_Array_size_log;
  localparam int unsigned SYM_MAX = T_MAX_WORDS * 8;
  localparam int unsigned AW      = $clog2(SYM_MAX);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned WW      = $clog2(T_MAX_WORDS) + 1;
  localparam int unsigned RW      = PE_Array_size_log + 1;
  localparam int unsigned VW      = V_E_F_Bit;
  localparam int unsigned SW      = V_E_F_Bit + 2;
  localparam logic [RW-1:0]        SV_FULL = '1;
  localparam logic signed [SW-1:0] ZERO_S  = '0;
  localparam logic signed [SW-1:0] HMAX_S  = $signed(SW'({VW{1'b1}}));

  typedef enum logic [1:0] {IDLE, LOAD_T, CAL, DONE} state_t;

  state_t              state_q, state_d;
  logic                busy_q, valid_q, req_q, run_q, first_q, last_q;
  logic [VW-1:0]       result_q, max_q, h_left_q, e_left_q, diag_q;
  logic [3:0]          match_q, mism_q, alpha_q, beta_q;
  logic [WW-1:0]       twords_q;
  logic [2*PE_NUM-1:0] s_q;
  logic [RW-1:0]       rows_q, row_q;
  logic [CW-1:0]       col_q;
  logic [15:0]         t_mem  [T_MAX_WORDS];
  logic [VW-1:0]       bh_mem [SYM_MAX];
  logic [VW-1:0]       bf_mem [SYM_MAX];

  logic [CW-1:0]       tlen_c;
  logic                t_we_c, cell_c, col_last_c, chunk_end_c, top_zero_c;
  logic [15:0]         t_word_c;
  logic [1:0]          t_sym_c, s_sym_c;
  logic [VW-1:0]       up_h_c, up_f_c, e_c, f_c, h_c, max_nxt_c;
  logic signed [SW-1:0] e_s, f_s, d_s, h_s;

  function automatic logic signed [SW-1:0] sx(input logic [VW-1:0] v);
    return $signed(SW'(v));
  endfunction

  function automatic logic signed [SW-1:0] smax(input logic signed [SW-1:0] a,
                                                input logic signed [SW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // One matrix cell per cycle at (row_q, col_q); boundary buffer holds the row above
  always_comb begin
    tlen_c      = CW'({twords_q, 3'b000});
    t_we_c      = (state_q == LOAD_T) && i_t[17] && (twords_q < WW'(T_MAX_WORDS));
    cell_c      = (state_q == CAL) && run_q && (tlen_c != '0);
    col_last_c  = (col_q == tlen_c - CW'(1));
    chunk_end_c = (tlen_c == '0) || (col_last_c && (row_q == rows_q - RW'(1)));
    top_zero_c  = first_q && (row_q == '0);
    t_word_c    = t_mem[col_q[AW-1:3]];
    t_sym_c     = t_word_c[{col_q[2:0], 1'b0} +: 2];
    s_sym_c     = s_q[{row_q[RW-2:0], 1'b0} +: 2];
    up_h_c      = top_zero_c ? '0 : bh_mem[col_q[AW-1:0]];
    up_f_c      = top_zero_c ? '0 : bf_mem[col_q[AW-1:0]];
    e_s = smax(smax(sx(h_left_q) - sx(VW'(alpha_q)), sx(e_left_q) - sx(VW'(beta_q))), ZERO_S);
    f_s = smax(smax(sx(up_h_c) - sx(VW'(alpha_q)), sx(up_f_c) - sx(VW'(beta_q))), ZERO_S);
    d_s = sx(diag_q) + ((s_sym_c == t_sym_c) ? sx(VW'(match_q)) : -sx(VW'(mism_q)));
    h_s = smax(smax(ZERO_S, e_s), smax(f_s, d_s));
    e_c = VW'(e_s);
    f_c = VW'(f_s);
    h_c = (h_s > HMAX_S) ? '1 : VW'(h_s);
    max_nxt_c = (cell_c && (h_c > max_q)) ? h_c : max_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_set_t) state_d = LOAD_T;
               else if (i_start_cal) state_d = CAL;
      LOAD_T:  if (i_t[17] && i_t[16]) state_d = IDLE;
      CAL:     if (run_q && chunk_end_c && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;  valid_q  <= 1'b0;  req_q    <= 1'b0;  run_q   <= 1'b0;
      first_q  <= 1'b0;  last_q   <= 1'b0;  result_q <= '0;     max_q   <= '0;
      h_left_q <= '0;    e_left_q <= '0;    diag_q   <= '0;     twords_q <= '0;
      match_q  <= '0;    mism_q   <= '0;    alpha_q  <= '0;     beta_q  <= '0;
      s_q      <= '0;    rows_q   <= '0;    row_q    <= '0;     col_q   <= '0;
    end else begin
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (i_set_t) begin
            twords_q <= '0;
          end else if (i_start_cal) begin
            match_q <= i_match;  mism_q <= i_mismatch;
            alpha_q <= i_minusAlpha;  beta_q <= i_minusBeta;
            max_q <= '0;  result_q <= '0;  req_q <= 1'b1;
            run_q <= 1'b0;  first_q <= 1'b1;  last_q <= 1'b0;
          end
        end
        LOAD_T: if (t_we_c) twords_q <= twords_q + WW'(1);
        CAL: begin
          if (req_q && (i_s_valid != '0)) begin
            s_q    <= i_s;
            rows_q <= ((i_s_valid == SV_FULL) || (i_s_valid > RW'(PE_NUM))) ? RW'(PE_NUM) : i_s_valid;
            last_q <= (i_s_valid != SV_FULL);
            req_q  <= 1'b0;  run_q <= 1'b1;
            row_q  <= '0;  col_q <= '0;
            h_left_q <= '0;  e_left_q <= '0;  diag_q <= '0;
          end else if (run_q) begin
            max_q <= max_nxt_c;
            if ((tlen_c == '0) || col_last_c) begin
              col_q <= '0;  row_q <= row_q + RW'(1);
              h_left_q <= '0;  e_left_q <= '0;  diag_q <= '0;
            end else begin
              col_q <= col_q + CW'(1);
              h_left_q <= h_c;  e_left_q <= e_c;  diag_q <= up_h_c;
            end
            if (chunk_end_c) begin
              run_q <= 1'b0;  first_q <= 1'b0;  req_q <= ~last_q;
              if (last_q) result_q <= max_nxt_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; T length and first-chunk flag qualify their contents
  always_ff @(posedge clk) begin
    if (t_we_c) t_mem[twords_q[WW-2:0]] <= i_t[15:0];
    if (cell_c) begin
      bh_mem[col_q[AW-1:0]] <= h_c;
      bf_mem[col_q[AW-1:0]] <= f_c;
    end
  end

  assign o_busy      = busy_q;
  assign o_valid     = valid_q;
  assign o_request_s = req_q;
  assign o_result    = result_q;

endmodule

// File: tb/tb_smith_waterman.sv
// Bench for smith_waterman: directed and random alignments scored against a full-matrix
// affine-gap reference computed inside the bench.
module tb_smith_waterman;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_set_t = 1'b0, i_start_cal = 1'b0;
  logic         o_busy, o_valid, o_request_s;
  logic [15:0]  o_result;
  logic [17:0]  i_t = '0;
  logic [127:0] i_s = '0;
  logic [6:0]   i_s_valid = '0;
  logic [3:0]   i_match = '0, i_mismatch = '0, i_minusAlpha = '0, i_minusBeta = '0;

  int total = 0;
  int bad   = 0;
  int tsyms[$];

  always #5 clk = ~clk;

  smith_waterman dut (
    .clk(clk), .rst(rst), .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .o_busy(o_busy), .o_result(o_result), .o_valid(o_valid), .o_request_s(o_request_s),
    .i_t(i_t), .i_s(i_s), .i_s_valid(i_s_valid),
    .i_match(i_match), .i_mismatch(i_mismatch),
    .i_minusAlpha(i_minusAlpha), .i_minusBeta(i_minusBeta)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Textbook full DP matrix with zero first row/column; E/F floored at 0, H saturated
  function automatic int sw_ref(input int t[$], input int s[$], input int m, input int mm,
                                input int a, input int b);
    int lt = t.size();
    int ls = s.size();
    int hm[], em[], fm[];
    int best = 0;
    hm = new[(ls + 1) * (lt + 1)];
    em = new[(ls + 1) * (lt + 1)];
    fm = new[(ls + 1) * (lt + 1)];
    for (int i = 1; i <= ls; i++) begin
      for (int j = 1; j <= lt; j++) begin
        int idx = i * (lt + 1) + j;
        int h;
        em[idx] = imax(0, imax(hm[idx - 1] - a, em[idx - 1] - b));
        fm[idx] = imax(0, imax(hm[idx - lt - 1] - a, fm[idx - lt - 1] - b));
        h = hm[idx - lt - 2] + ((s[i - 1] == t[j - 1]) ? m : -mm);
        h = imax(imax(0, h), imax(em[idx], fm[idx]));
        if (h > 65535) h = 65535;
        hm[idx] = h;
        best = imax(best, h);
      end
    end
    return best;
  endfunction

  task automatic load_t(input logic [15:0] w[$]);
    @(negedge clk);
    i_set_t = 1'b1;
    @(negedge clk);
    i_set_t = 1'b0;
    check("load_busy", 32'(o_busy), 1);
    for (int k = 0; k < w.size(); k++) begin
      if ($urandom_range(0, 1) == 1) begin
        i_t = {2'b01, 16'($urandom)};
        @(negedge clk);
      end
      i_t = {1'b1, (k == w.size() - 1), w[k]};
      @(negedge clk);
    end
    i_t = '0;
    check("load_done", 32'(o_busy), 0);
    tsyms.delete();
    for (int k = 0; k < w.size(); k++)
      for (int p = 0; p < 8; p++) tsyms.push_back(int'((w[k] >> (2 * p)) & 16'h3));
  endtask

  task automatic run_cal(input string tag, input int s[$], input int m, input int mm,
                         input int a, input int b, input bit disturb,
                         input logic [31:0] exp, input int exp_chunks);
    int pos = 0, nch = 0, extra = 0, cyc = 0, budget;
    bit fin = 1'b0, got = 1'b0, sent = 1'b0;
    logic [31:0] res = '0;
    budget = s.size() * (tsyms.size() + 2) + 1000;
    @(negedge clk);
    i_match = 4'(m); i_mismatch = 4'(mm); i_minusAlpha = 4'(a); i_minusBeta = 4'(b);
    i_start_cal = 1'b1;
    @(negedge clk);
    i_start_cal = 1'b0;
    while (!got && cyc < budget) begin
      if (sent) begin
        check({tag, "_req_drop"}, 32'(o_request_s), 0);
        sent = 1'b0;
      end
      i_start_cal = 1'b0;
      i_set_t = 1'b0;
      if (o_valid) begin
        got = 1'b1;
        res = 32'(o_result);
        check({tag, "_busy_at_valid"}, 32'(o_busy), 1);
      end else if (o_request_s) begin
        if (fin) extra++;
        else if ($urandom_range(0, 3) != 0) begin
          int rem = s.size() - pos;
          int take = (rem > 64) ? 64 : rem;
          i_s = {$urandom, $urandom, $urandom, $urandom};
          for (int k = 0; k < take; k++) i_s[2 * k +: 2] = 2'(s[pos + k]);
          i_s_valid = (rem > 64) ? 7'h7f : 7'(rem);
          fin = (rem <= 64);
          pos += take;
          nch++;
          sent = 1'b1;
        end
      end
      if (disturb && cyc == 30) begin
        i_start_cal = 1'b1;
        i_set_t = 1'b1;
      end
      if (!got) begin
        @(negedge clk);
        i_s_valid = '0;
        cyc++;
      end
    end
    i_start_cal = 1'b0;
    i_set_t = 1'b0;
    check({tag, "_valid_seen"}, 32'(got), 1);
    if (got) begin
      check({tag, "_result"}, res, exp);
      check({tag, "_no_rerequest"}, 32'(extra), 0);
      @(negedge clk);
      check({tag, "_valid_pulse"}, 32'(o_valid), 0);
      check({tag, "_busy_fall"}, 32'(o_busy), 0);
      if (exp_chunks >= 0) check({tag, "_chunks"}, 32'(nch), 32'(exp_chunks));
    end
  endtask

  initial begin
    logic [15:0] w[$];
    int s[$];
    int m, mm, a, b;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_req", 32'(o_request_s), 0);
    check("rst_result", 32'(o_result), 0);

    // T = "ACGT" (rest of word is A), exact match of S
    w = '{16'h00E4};
    load_t(w);
    s = '{0, 1, 2, 3};
    run_cal("acgt", s, 2, 1, 2, 1, 1'b0, 8, 1);

    // T = "ACT", one-symbol gap in T
    w = '{16'h0034};
    load_t(w);
    run_cal("gap", s, 2, 1, 1, 1, 1'b0, 5, 1);

    // set_t and start_cal together: load wins, no request appears
    @(negedge clk);
    i_set_t = 1'b1; i_start_cal = 1'b1;
    @(negedge clk);
    i_set_t = 1'b0; i_start_cal = 1'b0;
    check("both_busy", 32'(o_busy), 1);
    check("both_req", 32'(o_request_s), 0);
    i_t = {2'b11, 16'h0000};
    @(negedge clk);
    i_t = '0;
    check("both_req2", 32'(o_request_s), 0);
    check("both_done", 32'(o_busy), 0);
    tsyms.delete();
    for (int k = 0; k < 8; k++) tsyms.push_back(0);
    s = '{1, 1, 1, 1};
    run_cal("floor", s, 1, 1, 1, 1, 1'b0, 0, 1);

    // 136 A's in T, 130 A's in S over three chunks
    w.delete();
    for (int k = 0; k < 17; k++) w.push_back(16'h0000);
    load_t(w);
    s.delete();
    for (int k = 0; k < 130; k++) s.push_back(0);
    run_cal("long", s, 2, 1, 2, 1, 1'b0, 260, 3);

    // Random T/S/penalties against the reference; first run also pokes start/set while busy
    for (int r = 0; r < 5; r++) begin
      string tag;
      w.delete();
      for (int k = 0; k < $urandom_range(1, 4); k++) w.push_back(16'($urandom));
      load_t(w);
      s.delete();
      for (int k = 0; k < $urandom_range((r == 0) ? 40 : 1, 140); k++)
        s.push_back(int'($urandom_range(0, 3)));
      m = $urandom_range(1, 15); mm = $urandom_range(0, 15);
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      tag = $sformatf("rnd%0d", r);
      run_cal(tag, s, m, mm, a, b, (r == 0), 32'(sw_ref(tsyms, s, m, mm, a, b)),
              (s.size() + 63) / 64);
    end

    // Reset in the middle of a calculation
    @(negedge clk);
    i_match = 4'd2; i_mismatch = 4'd1; i_minusAlpha = 4'd2; i_minusBeta = 4'd1;
    i_start_cal = 1'b1;
    @(negedge clk);
    i_start_cal = 1'b0;
    for (int k = 0; k < 10 && !o_request_s; k++) @(negedge clk);
    check("mid_req", 32'(o_request_s), 1);
    i_s = '0;
    i_s_valid = 7'h7f;
    @(negedge clk);
    i_s_valid = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_req", 32'(o_request_s), 0);
    check("mid_rst_valid", 32'(o_valid), 0);
    rst = 1'b0;
    tsyms.delete();

    // Zero-length T after reset still consumes chunks and reports 0
    s.delete();
    for (int k = 0; k < 70; k++) s.push_back(int'($urandom_range(0, 3)));
    run_cal("zero_t", s, 3, 1, 2, 1, 1'b0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
